// File: rtl/data_memory_responder.sv
// Byte-addressed, big-endian data RAM for the MEM stage. It accepts one request,
// waits WAIT_STATES cycles, then pulses ready (and err for misaligned words).
module data_memory_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_e,
   input  logic                  mem_rw,
   input  logic                  mem_size,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  ready,
   output logic                  err
);
   localparam int         DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t                state_reg, state_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic                  capture;
   logic                  fire;

   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  rw_reg;
   logic                  size_reg;
   logic [31:0]           wdata_reg;
   logic [31:0]           rdata_reg;
   logic                  err_reg;

   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  acc_rw;
   logic                  acc_size;
   logic [31:0]           acc_wdata;
   logic                  misaligned;

   logic [ADDR_WIDTH-1:0] lane_addr  [4];
   logic [7:0]            lane_wdata [4];
   logic [7:0]            lane_rdata [4];

   logic [7:0]            mem [0:DEPTH-1];

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      fire       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (mem_e) begin
               capture  = 1'b1;
               cnt_next = WAIT_INIT;
               if (WAIT_STATES == 0) begin
                  state_next = ST_RESP;
                  fire       = 1'b1;
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_reg == 4'd1) begin
               state_next = ST_RESP;
               cnt_next   = 4'd0;
               fire       = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // With zero wait states the access completes on the accept edge itself,
   // so the live request is used instead of the not-yet-captured copy.
   always_comb begin
      acc_addr  = addr_reg;
      acc_rw    = rw_reg;
      acc_size  = size_reg;
      acc_wdata = wdata_reg;
      if (state_reg == ST_IDLE) begin
         acc_addr  = addr;
         acc_rw    = mem_rw;
         acc_size  = mem_size;
         acc_wdata = wdata;
      end
   end

   assign misaligned = acc_size && (acc_addr[1:0] != 2'b00);

   // Lane 0 holds the most significant byte (big-endian).
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
         assign lane_addr[gi]  = {acc_addr[ADDR_WIDTH-1:2], 2'(gi)};
         assign lane_wdata[gi] = acc_wdata[31-8*gi -: 8];
         assign lane_rdata[gi] = mem[lane_addr[gi]];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         addr_reg  <= '0;
         rw_reg    <= 1'b0;
         size_reg  <= 1'b0;
         wdata_reg <= 32'h0;
         rdata_reg <= 32'h0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= fire && misaligned;
         if (capture) begin
            addr_reg  <= addr;
            rw_reg    <= mem_rw;
            size_reg  <= mem_size;
            wdata_reg <= wdata;
         end
         if (fire) begin
            if (misaligned) begin
               rdata_reg <= 32'h0;
            end else if (!acc_rw) begin
               rdata_reg <= acc_size ?
                  {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]} :
                  {24'h0, mem[acc_addr]};
            end
         end
      end
   end

   // RAM contents survive reset; an access aborted by reset never writes.
   always_ff @(posedge clk) begin
      if (fire && !reset && acc_rw && !misaligned) begin
         if (acc_size) begin
            for (int k = 0; k < 4; k++) begin
               mem[lane_addr[k]] <= lane_wdata[k];
            end
         end else begin
            mem[acc_addr] <= acc_wdata[7:0];
         end
      end
   end

   assign ready = (state_reg == ST_RESP);
   assign err   = err_reg;
   assign rdata = rdata_reg;
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Byte-addressed data RAM that serves the MEM stage of the ARM pipeline.
- The EX/MEM register is the initiator. It drives enable, read/write, size, address and store data. This block completes each access after a programmable number of wait states and returns a one-cycle ready pulse, which the hazard logic uses to stall.
- Supports byte and word transfers, big-endian, with misaligned-word detection.

Parameters:
ADDR_WIDTH, 8, address width; memory depth = 2**ADDR_WIDTH bytes.
WAIT_STATES, 2, extra cycles between accept and response; legal range 0..15.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
mem_e  input  1  request valid (EX/MEM memory enable)
mem_rw  input  1  1 = write (store), 0 = read (load)
mem_size  input  1  1 = word (32-bit), 0 = byte
addr  input  ADDR_WIDTH  byte address
wdata  input  32  store data
rdata  output  32  load data
ready  output  1  one-cycle completion pulse
err  output  1  misaligned word access, pulses with ready

Behaviour:
- Reset: one clock, synchronous, active-high, as above.
  - On reset: rdata=0, ready=0, err=0, wait counter=0, state=IDLE.
  - RAM array Mem[0:2**ADDR_WIDTH-1] (8-bit entries) is NOT cleared. Benches preload it hierarchically.
- State IDLE:
  - At a rising edge with mem_e=1: capture addr, mem_rw, mem_size and wdata into internal registers.
  - Counter is loaded with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
  - mem_e=0: stay in IDLE.
- State WAIT:
  - Counter decrements each edge; go to RESP at the edge where counter reaches 1.
  - mem_e and all inputs are ignored. The initiator holds the request stable until ready; the block uses only the captured copy.
- State RESP:
  - ready=1 for exactly this cycle.
  - Next edge always returns to IDLE. A request still asserted at that edge is NOT re-accepted.
  - Minimum spacing between accepts is 2+WAIT_STATES cycles.
- Latency:
  - Request accepted at edge E0.
  - ready is high during the cycle following edge E0+WAIT_STATES.
  - WAIT_STATES=0 gives ready in the cycle right after E0.
- Data performed on the edge entering RESP (registered):
  - Byte write: Mem[a] <= wdata[7:0].
  - Word write (big-endian): Mem[a]<=wdata[31:24], Mem[a+1]<=wdata[23:16], Mem[a+2]<=wdata[15:8], Mem[a+3]<=wdata[7:0].
  - Byte read: rdata <= {24'b0, Mem[a]}.
  - Word read: rdata <= {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}.
  - Writes leave rdata unchanged.
  - rdata holds its value until the next completed read or reset.
- Alignment:
  - Word access with captured addr[1:0]!=0: no RAM write, rdata <= 0, err=1 together with ready, same timing.
  - Byte accesses never raise err.
  - Aligned words never cross the top of memory, so no address wrap exists.
- Reset mid-operation: reset during WAIT aborts the access. No RAM write occurs, no ready pulse, state=IDLE.
- mem_e with X/undefined mode bits is outside scope. Only 0/1 are specified.

Test Plan:
- Preload Mem[16..19]=8'hDE,8'hAD,8'hBE,8'hEF; WAIT_STATES=2; word read addr=16 accepted at edge E0 -> ready=1, rdata=32'hDEADBEEF, err=0 in cycle after E0+2; ready low before and after.
- Word write addr=32, wdata=32'h11223344, then byte read addr=34 -> Mem[32..35]=11,22,33,44; rdata=32'h00000033; rdata unchanged across the write.
- Byte write addr=7, wdata=32'hFFFFFFA5 -> only Mem[7]=8'hA5; Mem[4..6] and Mem[8] unchanged.
- Word read addr=18 (misaligned) -> ready and err both 1 for one cycle; rdata=0. Word write addr=33 -> err=1 and no byte of Mem[32..36] modified.
- mem_e held high continuously with WAIT_STATES=0 -> ready pulses every 2nd cycle, never two consecutive cycles high. With WAIT_STATES=2 -> one pulse every 4 cycles.
- Word write to addr=40 started, reset asserted during WAIT -> no ready pulse; Mem[40..43] keep preload values; rdata=0; next request is accepted normally from IDLE.
